vga_keyboard_render: RTL and testbench
======================================

// Module: vga_keyboard_render
// PURPOSE
//  Pixel-colour stage feeding the VGA output pins. Consumes the pixel
//  coordinates and raw sync signals of the 800x525 (640x480 visible) VGA
//  timing counter and renders an on-screen piano keyboard: NKEYS equal-width
//  keys; pressed keys show red, fading back to white over 7 frames.
//  Outputs sync and 9-bit RGB aligned to each other, 2 clocks after input.
// PARAMETERS
//  NKEYS   16   number of keys drawn, left to right, key 0 at x=0
//  KEY_W   40   key width in pixels (NKEYS*KEY_W <= 640)
//  KB_TOP  320  first visible row of the keyboard area
//  UPD_Y   480  row whose x=0 pixel triggers the per-frame key/fade update
//  BG_B    2    blue level of the background above the keyboard
// PORTS
//  clk     in   1      pixel clock
//  rst     in   1      reset, asynchronous, active-high
//  x_in    in   16     pixel column, 0..799, increments by 1 per clk, wraps to 0
//  y_in    in   16     pixel row, 0..524, changes only when x_in wraps to 0
//  hs_in   in   1      horizontal sync from the timing counter, active-low
//  vs_in   in   1      vertical sync from the timing counter, active-low
//  keys    in   NKEYS  key-pressed bitmask, bit i = key i, level-sensitive
//  hs_out  out  1      hs_in delayed 2 clks
//  vs_out  out  1      vs_in delayed 2 clks
//  r,g,b   out  3 each colour for the pixel presented 2 clks earlier
// BEHAVIOUR
//  - Reset: all pipeline regs, hs_out, vs_out, r, g and b are 0. All fade
//    levels and latched keys are 0. Reset mid-frame discards in-flight pixels.
//  - Stage 1 (edge 1) registers x, y, hs and vs, plus the key counters
//    kidx/kpix. Counter next value:
//    - x_in==0 -> (0,0);
//    - else kpix==KEY_W-1 -> (kidx+1,0);
//    - else (kidx,kpix+1).
//    - kidx saturates at NKEYS; kidx==NKEYS means outside the keyboard.
//  - Stage 2 (edge 2) registers hs_out, vs_out and rgb from the stage-1 values.
//    - Latency is exactly 2 clks for every output; no bubbles, no stalls.
//  - Colour, evaluated on the stage-1 values, first rule that matches wins:
//    1) x>=640 or y>=480 (blanking): rgb=0.
//    2) y<KB_TOP: r=0, g=0, b=BG_B.
//    3) kidx==NKEYS: r=g=b=0.
//    4) kpix==0 (key border): r=g=b=0.
//    5) key kidx with fade level L (0..7): r=7, g=7-L, b=7-L.
//       L=0 is white 777, L=7 is red 700.
//  - Frame update: fires on the edge where stage 1 holds x==0 and y==UPD_Y.
//    - Per key i: keys[i]==1 -> L_i=7; else L_i>0 -> L_i=L_i-1; else L_i stays 0.
//    - keys is sampled only at that edge; presses shorter than one frame
//      between updates are not shown.
//  - Levels are constant over all visible rows, so there is no tearing.
//  - Fade arithmetic: 3-bit unsigned, never wraps below 0 or above 7.
// TESTING
//  T1 reset: assert rst mid-line -> hs_out=vs_out=0 and rgb=0 immediately.
//     After release, the first valid pixel appears 2 clks after the first x_in.
//  T2 alignment: drive full 800x525 frames with keys=0. Then:
//     - hs_out low exactly for x 656..751, 2 clks late;
//     - y=100: rgb=0,0,2;
//     - y=400, x=41: 777; x=40 and x=80: 000.
//  T3 press: keys[3]=1 across the UPD_Y update.
//     - Next frame, y=400, x=130: rgb=7,0,0.
//     - Key 2 (x=90) stays 777.
//  T4 fade: release key 3 after T3 -> pixel x=130 reads 7,1,1 then 7,2,2
//     ... 7,7,7 on successive frames; stays 777 thereafter.
//  T5 re-press: re-assert keys[3] while L=3 -> next frame L=7 (700).
//     Also a keys pulse that misses the update edge -> no colour change.
//  T6 config: NKEYS=10, KEY_W=50. Then:
//     - x=499 gets key 9's colour;
//     - x>=500 within y 320..479 -> rgb=0;
//     - x=0 border column is black.

Source files
------------

// File: rtl/vga_keyboard_render.sv
// Pixel-colour stage for a 640x480 VGA raster: draws an NKEYS piano keyboard whose
// pressed keys show red and fade back to white over 7 frames. Two-clock latency.
module vga_keyboard_render #(
  parameter int NKEYS  = 16,
  parameter int KEY_W  = 40,
  parameter int KB_TOP = 320,
  parameter int UPD_Y  = 480,
  parameter int BG_B   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      x_in,
  input  logic [15:0]      y_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [NKEYS-1:0] keys,
  output logic             hs_out,
  output logic             vs_out,
  output logic [2:0]       r,
  output logic [2:0]       g,
  output logic [2:0]       b
);

  localparam int KI_W = $clog2(NKEYS + 1);
  localparam int KP_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  // Fade step: a held key jumps to full red, otherwise decay towards 0 without wrapping.
  function automatic logic [2:0] fade_step(input logic pressed, input logic [2:0] lvl);
    if (pressed)            return 3'd7;
    else if (lvl != 3'd0)   return lvl - 3'd1;
    else                    return 3'd0;
  endfunction

  function automatic logic [8:0] pixel_colour(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        in_kb,
    input logic        border,
    input logic [2:0]  lvl
  );
    if (x >= 16'd640 || y >= 16'd480) return 9'd0;
    else if (y < 16'(KB_TOP))         return {3'd0, 3'd0, 3'(BG_B)};
    else if (!in_kb)                  return 9'd0;
    else if (border)                  return 9'd0;
    else                              return {3'd7, 3'd7 - lvl, 3'd7 - lvl};
  endfunction

  logic            vld_p1_q, vld_p1_d;
  logic [15:0]     x_p1_q, x_p1_d;
  logic [15:0]     y_p1_q, y_p1_d;
  logic            hs_p1_q, hs_p1_d;
  logic            vs_p1_q, vs_p1_d;
  logic [KI_W-1:0] kidx_p1_q, kidx_p1_d;
  logic [KP_W-1:0] kpix_p1_q, kpix_p1_d;

  logic            hs_p2_q, hs_p2_d;
  logic            vs_p2_q, vs_p2_d;
  logic [8:0]      rgb_p2_q, rgb_p2_d;

  logic [2:0]      lvl_q [NKEYS];
  logic [2:0]      lvl_d [NKEYS];

  logic            in_kb_p1;
  logic [2:0]      lvl_sel_p1;
  logic            upd_p1;

  // Stage 0 -> 1: register the raster position and walk the key counters along the line.
  always_comb begin
    vld_p1_d = 1'b1;
    x_p1_d   = x_in;
    y_p1_d   = y_in;
    hs_p1_d  = hs_in;
    vs_p1_d  = vs_in;
    if (x_in == 16'd0) begin
      kidx_p1_d = '0;
      kpix_p1_d = '0;
    end else if (kidx_p1_q == KI_W'(NKEYS)) begin
      kidx_p1_d = kidx_p1_q;
      kpix_p1_d = '0;
    end else if (kpix_p1_q == KP_W'(KEY_W - 1)) begin
      kidx_p1_d = kidx_p1_q + 1'b1;
      kpix_p1_d = '0;
    end else begin
      kidx_p1_d = kidx_p1_q;
      kpix_p1_d = kpix_p1_q + 1'b1;
    end
  end

  // Stage 1 -> 2: colour lookup; an invalid stage-1 slot (just after reset) emits zeros.
  always_comb begin
    in_kb_p1   = (kidx_p1_q != KI_W'(NKEYS));
    lvl_sel_p1 = 3'd0;
    for (int i = 0; i < NKEYS; i++) begin
      if (kidx_p1_q == KI_W'(i)) lvl_sel_p1 = lvl_q[i];
    end
    if (vld_p1_q) begin
      hs_p2_d  = hs_p1_q;
      vs_p2_d  = vs_p1_q;
      rgb_p2_d = pixel_colour(x_p1_q, y_p1_q, in_kb_p1, (kpix_p1_q == '0), lvl_sel_p1);
    end else begin
      hs_p2_d  = 1'b0;
      vs_p2_d  = 1'b0;
      rgb_p2_d = 9'd0;
    end
  end

  // Levels change once per frame, below the visible area, so every visible row agrees.
  always_comb begin
    upd_p1 = vld_p1_q && (x_p1_q == 16'd0) && (y_p1_q == 16'(UPD_Y));
    for (int i = 0; i < NKEYS; i++) begin
      lvl_d[i] = upd_p1 ? fade_step(keys[i], lvl_q[i]) : lvl_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      x_p1_q    <= '0;
      y_p1_q    <= '0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
      kidx_p1_q <= '0;
      kpix_p1_q <= '0;
      hs_p2_q   <= 1'b0;
      vs_p2_q   <= 1'b0;
      rgb_p2_q  <= '0;
      for (int i = 0; i < NKEYS; i++) lvl_q[i] <= 3'd0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      x_p1_q    <= x_p1_d;
      y_p1_q    <= y_p1_d;
      hs_p1_q   <= hs_p1_d;
      vs_p1_q   <= vs_p1_d;
      kidx_p1_q <= kidx_p1_d;
      kpix_p1_q <= kpix_p1_d;
      hs_p2_q   <= hs_p2_d;
      vs_p2_q   <= vs_p2_d;
      rgb_p2_q  <= rgb_p2_d;
      for (int i = 0; i < NKEYS; i++) lvl_q[i] <= lvl_d[i];
    end
  end

  assign hs_out    = hs_p2_q;
  assign vs_out    = vs_p2_q;
  assign {r, g, b} = rgb_p2_q;

endmodule

// File: tb/tb_vga_keyboard_render.sv
// Directed bench for vga_keyboard_render: default 16x40 keyboard plus a 10x50 variant
// driven by the same raster; only the rows of interest are scanned, each as a full line.
module tb_vga_keyboard_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x_in = '0, y_in = '0;
  logic        hs_in = 1'b1, vs_in = 1'b1;
  logic [15:0] keys_a = '0;
  logic [9:0]  keys_b = '0;
  logic        hs_out_a, vs_out_a, hs_out_b, vs_out_b;
  logic [2:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  int errors = 0;
  int checks = 0;

  logic [8:0] obs_a [800];
  logic [8:0] obs_b [800];
  logic       obs_hs [800];
  logic       obs_vs [800];

  always #5 clk = ~clk;

  vga_keyboard_render dut_a (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .hs_in(hs_in), .vs_in(vs_in),
    .keys(keys_a), .hs_out(hs_out_a), .vs_out(vs_out_a), .r(r_a), .g(g_a), .b(b_a)
  );

  vga_keyboard_render #(.NKEYS(10), .KEY_W(50)) dut_b (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .hs_in(hs_in), .vs_in(vs_in),
    .keys(keys_b), .hs_out(hs_out_b), .vs_out(vs_out_b), .r(r_b), .g(g_b), .b(b_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Scan one full line starting at a negedge; obs[i] is sampled before pixel i is driven,
  // so pixel p's result lands in obs[p+2].
  task automatic run_line(input int y, input int pulse_key);
    for (int i = 0; i < 800; i++) begin
      obs_a[i]  = {r_a, g_a, b_a};
      obs_b[i]  = {r_b, g_b, b_b};
      obs_hs[i] = hs_out_a;
      obs_vs[i] = vs_out_a;
      x_in  = 16'(i);
      y_in  = 16'(y);
      hs_in = !(i >= 656 && i < 752);
      vs_in = !(y == 490 || y == 491);
      if (pulse_key >= 0) keys_a[pulse_key] = (i >= 100 && i < 300);
      @(negedge clk);
    end
  endtask

  // One update row with the given keys held, then a visible keyboard row to inspect.
  task automatic frame(input logic [15:0] ka, input logic [9:0] kb);
    keys_a = ka;
    keys_b = kb;
    run_line(480, -1);
    keys_a = '0;
    keys_b = '0;
    run_line(400, -1);
  endtask

  function automatic logic [8:0] pa(input int p);
    return obs_a[p + 2];
  endfunction

  function automatic logic [8:0] pb(input int p);
    return obs_b[p + 2];
  endfunction

  initial begin
    int hs_bad;
    repeat (3) @(negedge clk);
    chk("rst_hs", 16'(hs_out_a), 16'd0);
    chk("rst_vs", 16'(vs_out_a), 16'd0);
    chk("rst_rgb", 16'({r_a, g_a, b_a}), 16'd0);

    // Alignment and static picture with no keys ever pressed.
    rst = 1'b0;
    run_line(100, -1);
    chk("first_pix_gap", 16'(obs_a[1]), 16'd0);
    chk("bg_y100", 16'(pa(5)), 16'o002);
    chk("bg_y100_x639", 16'(pa(639)), 16'o002);
    chk("blank_x700", 16'(pa(700)), 16'o000);
    hs_bad = 0;
    for (int p = 2; p < 798; p++) begin
      if (obs_hs[p + 2] !== ((p >= 656 && p < 752) ? 1'b0 : 1'b1)) hs_bad++;
    end
    chk("hs_window", 16'(hs_bad), 16'd0);
    chk("vs_high", 16'(obs_vs[102]), 16'd1);

    run_line(400, -1);
    chk("white_x41", 16'(pa(41)), 16'o777);
    chk("border_x40", 16'(pa(40)), 16'o000);
    chk("border_x80", 16'(pa(80)), 16'o000);
    chk("border_x0", 16'(pa(0)), 16'o000);
    chk("last_key_x639", 16'(pa(639)), 16'o777);
    chk("off_kb_x640", 16'(pa(640)), 16'o000);
    chk("b_x499", 16'(pb(499)), 16'o777);
    chk("b_x500", 16'(pb(500)), 16'o000);
    chk("b_x600", 16'(pb(600)), 16'o000);
    chk("b_border_x0", 16'(pb(0)), 16'o000);
    chk("b_border_x50", 16'(pb(50)), 16'o000);
    chk("b_x51", 16'(pb(51)), 16'o777);

    run_line(490, -1);
    chk("vs_low", 16'(obs_vs[102]), 16'd0);
    chk("blank_y490", 16'(pa(100)), 16'o000);

    // Press key 3 (and key 9 on the 10-key variant) across one update.
    frame(16'h0008, 10'h200);
    chk("press_x130", 16'(pa(130)), 16'o700);
    chk("key2_x90", 16'(pa(90)), 16'o777);
    chk("b_press_x499", 16'(pb(499)), 16'o700);
    chk("b_key8_x449", 16'(pb(449)), 16'o777);

    for (int k = 1; k <= 7; k++) begin
      frame(16'h0000, 10'h000);
      chk($sformatf("fade_%0d", k), 16'(pa(130)), 16'({3'd7, 3'(k), 3'(k)}));
    end
    frame(16'h0000, 10'h000);
    chk("fade_hold", 16'(pa(130)), 16'o777);

    // Re-press while still fading.
    frame(16'h0008, 10'h000);
    chk("repress_full", 16'(pa(130)), 16'o700);
    for (int k = 1; k <= 4; k++) frame(16'h0000, 10'h000);
    chk("fade_to_3", 16'(pa(130)), 16'o744);
    frame(16'h0008, 10'h000);
    chk("repress_L3", 16'(pa(130)), 16'o700);

    // A key pulse confined to a visible row never reaches an update edge.
    frame(16'h0000, 10'h000);
    chk("after_repress", 16'(pa(130)), 16'o711);
    run_line(400, 5);
    keys_a = '0;
    frame(16'h0000, 10'h000);
    chk("pulse_key5", 16'(pa(210)), 16'o777);
    chk("key3_still_fading", 16'(pa(130)), 16'o722);

    // Reset in the middle of a line.
    for (int i = 0; i < 50; i++) begin
      x_in  = 16'(i);
      y_in  = 16'd100;
      hs_in = 1'b1;
      vs_in = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_bg", 16'({r_a, g_a, b_a}), 16'o002);
    rst = 1'b1;
    #1;
    chk("mid_rst_hs", 16'(hs_out_a), 16'd0);
    chk("mid_rst_vs", 16'(vs_out_a), 16'd0);
    chk("mid_rst_rgb", 16'({r_a, g_a, b_a}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run_line(100, -1);
    chk("post_rst_gap", 16'(obs_a[1]), 16'd0);
    chk("post_rst_first", 16'(pa(0)), 16'o002);
    chk("post_rst_hs", 16'(obs_hs[2]), 16'd1);
    run_line(400, -1);
    chk("rst_clears_fade", 16'(pa(130)), 16'o777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
